// File: rtl/keypad_scanner.sv
// Key-matrix scanner: column strobing, 2-flop row sync, frame-level debounce FSM
// and a small key-code FIFO that drives the 8-bit keypad byte ({valid,3'b000,code}).
module keypad_scanner #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [ROWS-1:0] row_in,
  output logic [COLS-1:0] col_out,
  input  logic            key_ack,
  output logic [7:0]      keypad,
  output logic            overflow
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PW    = AW + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [CNT_W-1:0] DS_C     = CNT_W'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {S_IDLE, S_PRESS_CHK, S_HELD, S_REL_CHK} state_t;

  logic [ROWS-1:0]  row_meta_q, row_sync_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [COL_W-1:0] col_idx_q, col_idx_d;
  logic [COLS-1:0]  col_out_q, col_out_d;
  logic             best_vld_q, best_vld_d;
  logic [3:0]       best_code_q, best_code_d;
  logic             tc_s, frame_end_s, col_hit_s, frame_vld_s;
  logic [3:0]       col_code_s, frame_code_s;
  state_t           state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_s;
  logic             push_q, push_d;
  logic [3:0]       push_code_q, push_code_d;
  logic [3:0]       mem_q [FIFO_DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d, count_s;
  logic             empty_s, full_s, pop_s, do_push_s;
  logic [3:0]       head_s;
  logic [7:0]       keypad_q, keypad_d;
  logic             overflow_q, overflow_d;

  // Two-flop synchronizer for the asynchronous row lines
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
    end else begin
      row_meta_q <= row_in;
      row_sync_q <= row_meta_q;
    end
  end

  // Divider, column strobe and per-frame lowest-code accumulation
  always_comb begin
    tc_s        = (div_q == DIV_LAST);
    frame_end_s = tc_s && (col_idx_q == COL_LAST);
    div_d       = tc_s ? '0 : div_q + DIV_W'(1);
    col_idx_d   = col_idx_q;
    if (tc_s) begin
      col_idx_d = (col_idx_q == COL_LAST) ? '0 : col_idx_q + COL_W'(1);
    end else begin
      col_idx_d = col_idx_q;
    end
    for (int c = 0; c < COLS; c++) begin
      col_out_d[c] = (col_idx_d != COL_W'(c));
    end
    // Walk rows high-to-low so the lowest pressed row wins in this column
    col_hit_s  = 1'b0;
    col_code_s = 4'h0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (!row_sync_q[r]) begin
        col_hit_s  = 1'b1;
        col_code_s = 4'(r * COLS) + 4'(col_idx_q);
      end else begin
        col_hit_s  = col_hit_s;
      end
    end
    if (col_hit_s && (!best_vld_q || (col_code_s < best_code_q))) begin
      frame_vld_s  = 1'b1;
      frame_code_s = col_code_s;
    end else begin
      frame_vld_s  = best_vld_q;
      frame_code_s = best_code_q;
    end
    best_vld_d  = best_vld_q;
    best_code_d = best_code_q;
    if (frame_end_s) begin
      best_vld_d  = 1'b0;
      best_code_d = 4'h0;
    end else if (tc_s) begin
      best_vld_d  = frame_vld_s;
      best_code_d = frame_code_s;
    end else begin
      best_vld_d  = best_vld_q;
    end
  end

  // Scan state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q       <= '0;
      col_idx_q   <= '0;
      col_out_q   <= {{(COLS-1){1'b1}}, 1'b0};
      best_vld_q  <= 1'b0;
      best_code_q <= 4'h0;
    end else begin
      div_q       <= div_d;
      col_idx_q   <= col_idx_d;
      col_out_q   <= col_out_d;
      best_vld_q  <= best_vld_d;
      best_code_q <= best_code_d;
    end
  end

  // Debounce FSM, stepped once per completed frame
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    push_d      = 1'b0;
    push_code_d = push_code_q;
    cnt_inc_s   = cnt_q + CNT_W'(1);
    if (frame_end_s) begin
      case (state_q)
        S_IDLE: begin
          if (frame_vld_s) begin
            cand_d = frame_code_s;
            cnt_d  = CNT_W'(1);
            if (DEBOUNCE_SCANS == 1) begin
              push_d      = 1'b1;
              push_code_d = frame_code_s;
              state_d     = S_HELD;
            end else begin
              state_d = S_PRESS_CHK;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_PRESS_CHK: begin
          if (!frame_vld_s) begin
            state_d = S_IDLE;
          end else if (frame_code_s == cand_q) begin
            cnt_d = cnt_inc_s;
            if (cnt_inc_s == DS_C) begin
              push_d      = 1'b1;
              push_code_d = cand_q;
              state_d     = S_HELD;
            end else begin
              state_d = S_PRESS_CHK;
            end
          end else begin
            cand_d = frame_code_s;
            cnt_d  = CNT_W'(1);
          end
        end
        S_HELD: begin
          if (frame_vld_s && (frame_code_s == cand_q)) begin
            state_d = S_HELD;
          end else if (DEBOUNCE_SCANS == 1) begin
            state_d = S_IDLE;
          end else begin
            cnt_d   = CNT_W'(1);
            state_d = S_REL_CHK;
          end
        end
        S_REL_CHK: begin
          if (frame_vld_s && (frame_code_s == cand_q)) begin
            state_d = S_HELD;
          end else if (cnt_inc_s == DS_C) begin
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_inc_s;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Debounce state registers; the push is registered and consumed by the FIFO next cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cand_q      <= 4'h0;
      cnt_q       <= '0;
      push_q      <= 1'b0;
      push_code_q <= 4'h0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      push_q      <= push_d;
      push_code_q <= push_code_d;
    end
  end

  // FIFO control; a pop frees room for a coincident push even when full
  always_comb begin
    count_s   = wptr_q - rptr_q;
    empty_s   = (count_s == '0);
    full_s    = (count_s == PW'(FIFO_DEPTH));
    pop_s     = key_ack && !empty_s;
    do_push_s = push_q && (!full_s || pop_s);
    wptr_d    = do_push_s ? wptr_q + PW'(1) : wptr_q;
    rptr_d    = pop_s ? rptr_q + PW'(1) : rptr_q;
    if (do_push_s && (rptr_d == wptr_q)) begin
      head_s = push_code_q;
    end else begin
      head_s = mem_q[rptr_d[AW-1:0]];
    end
    keypad_d = (wptr_d != rptr_d) ? {1'b1, 3'b000, head_s} : 8'h00;
    if (push_q && full_s && !pop_s) begin
      overflow_d = 1'b1;
    end else if (pop_s && (count_s == PW'(1)) && !do_push_s) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // FIFO storage, pointers and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 4'h0;
      end
      wptr_q     <= '0;
      rptr_q     <= '0;
      keypad_q   <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      if (do_push_s) begin
        mem_q[wptr_q[AW-1:0]] <= push_code_q;
      end
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      keypad_q   <= keypad_d;
      overflow_q <= overflow_d;
    end
  end

  assign col_out  = col_out_q;
  assign keypad   = keypad_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a key matrix model drives row_in from col_out, and a
// frame-level reference (run lengths of frame results + code queue) predicts keypad/overflow.
module tb_keypad_scanner;
  localparam int ROWS = 4, COLS = 4, SCAN_DIV = 4, DS = 2, DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic        key_ack;
  logic [7:0]  keypad;
  logic        overflow;
  logic [15:0] pressed;

  int n_checks = 0;
  int n_errors = 0;

  // reference state
  int q[$];
  bit m_ovf;
  int held, streak_key, streak, absent;

  keypad_scanner #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV),
                   .DEBOUNCE_SCANS(DS), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .row_in(row_in), .col_out(col_out),
    .key_ack(key_ack), .keypad(keypad), .overflow(overflow));

  always #5 clk = ~clk;

  // a pressed key shorts its row to its column while that column is driven low
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!col_out[c] && pressed[r*COLS+c]) row_in[r] = 1'b0;
  end

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] model_keypad();
    if (q.size() > 0) return 8'h80 | 8'(q[0]);
    return 8'h00;
  endfunction

  function automatic int lowest(input logic [15:0] k);
    for (int i = 0; i < 16; i++) if (k[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    held = -1; streak_key = -1; streak = 0; absent = 0;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "/keypad"}, keypad, model_keypad());
    check_eq({tag, "/overflow"}, {7'd0, overflow}, {7'd0, m_ovf});
  endtask

  // One 16-clk frame with a stable key set; starts and ends one clk after a frame boundary.
  task automatic frame(input logic [15:0] keys, input bit ack_mid, input bit ack_push, input string tag);
    int res;
    bit push, popped;
    pressed = keys;
    if (ack_mid) begin
      key_ack = 1'b1;
      tick(1);
      key_ack = 1'b0;
      if (q.size() > 0) begin
        void'(q.pop_front());
        if (q.size() == 0) m_ovf = 1'b0;
      end
      check_outputs({tag, "/ack"});
      tick(13);
    end else begin
      tick(14);
    end
    tick(1);
    if (ack_push) key_ack = 1'b1;
    res  = lowest(keys);
    push = 1'b0;
    if (held < 0) begin
      if (res < 0) streak = 0;
      else if (streak > 0 && res == streak_key) streak++;
      else begin streak_key = res; streak = 1; end
      if (streak >= DS) begin
        push = 1'b1; held = res; absent = 0; streak = 0;
      end
    end else begin
      if (res == held) absent = 0;
      else absent++;
      if (absent >= DS) begin held = -1; streak = 0; end
    end
    tick(1);
    key_ack = 1'b0;
    popped = ack_push && (q.size() > 0);
    if (popped) void'(q.pop_front());
    if (push) begin
      if (q.size() < DEPTH) q.push_back(res);
      else m_ovf = 1'b1;
    end
    if (popped && q.size() == 0) m_ovf = 1'b0;
    check_outputs(tag);
  endtask

  task automatic release_reset();
    pressed = 16'h0;
    @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    tick(1);
  endtask

  initial begin
    logic [15:0] cur;
    reset = 1'b0; key_ack = 1'b0; pressed = 16'h0;
    model_reset();
    #12;
    check_eq("rst_col", {4'h0, col_out}, 8'h0E);
    check_eq("rst_kp", keypad, 8'h00);
    check_eq("rst_ovf", {7'd0, overflow}, 8'h00);
    @(posedge clk);
    #1 reset = 1'b1;
    tick(4);
    check_eq("col_after4", {4'h0, col_out}, 8'h0D);
    tick(12);
    check_eq("col_after16", {4'h0, col_out}, 8'h0E);
    tick(1);

    // single key row1/col2 held, acked, held on
    repeat (3) frame(16'h0040, 1'b0, 1'b0, "t2_hold");
    check_eq("t2_code", keypad, 8'h86);
    frame(16'h0040, 1'b1, 1'b0, "t2_acked");
    check_eq("t2_empty", keypad, 8'h00);
    repeat (2) frame(16'h0040, 1'b0, 1'b0, "t2_nopush");
    repeat (2) frame(16'h0000, 1'b0, 1'b0, "t2_rel");

    // one-frame bounce on key 5
    frame(16'h0020, 1'b0, 1'b0, "t3_bounce");
    repeat (2) frame(16'h0000, 1'b0, 1'b0, "t3_none");
    check_eq("t3_kp", keypad, 8'h00);

    // five clean presses, fifo overflows
    for (int k = 0; k < 5; k++) begin
      repeat (2) frame(16'(1 << k), 1'b0, 1'b0, "t4_press");
      repeat (2) frame(16'h0000, 1'b0, 1'b0, "t4_rel");
    end
    check_eq("t4_ovf", {7'd0, overflow}, 8'h01);
    check_eq("t4_head", keypad, 8'h80);
    repeat (4) frame(16'h0000, 1'b1, 1'b0, "t4_drain");
    check_eq("t4_ovf_clr", {7'd0, overflow}, 8'h00);

    // keys 3 and 9 together, then 3 released
    repeat (3) frame(16'h0208, 1'b0, 1'b0, "t5_both");
    check_eq("t5_first", keypad, 8'h83);
    repeat (4) frame(16'h0200, 1'b0, 1'b0, "t5_nine");
    frame(16'h0200, 1'b1, 1'b0, "t5_ack");
    check_eq("t5_second", keypad, 8'h89);
    repeat (2) frame(16'h0000, 1'b1, 1'b0, "t5_drain");

    // full fifo with coincident push and pop
    for (int k = 10; k < 14; k++) begin
      repeat (2) frame(16'(1 << k), 1'b0, 1'b0, "t6_fill");
      repeat (2) frame(16'h0000, 1'b0, 1'b0, "t6_rel");
    end
    frame(16'h4000, 1'b0, 1'b0, "t6_cand");
    frame(16'h4000, 1'b0, 1'b1, "t6_coincide");
    check_eq("t6_head", keypad, 8'h8B);
    check_eq("t6_noovf", {7'd0, overflow}, 8'h00);
    repeat (3) frame(16'h0000, 1'b1, 1'b0, "t6_pop");
    repeat (3) frame(16'h0080, 1'b0, 1'b0, "t6_held");
    check_eq("t6_two", keypad, 8'h8E);
    reset = 1'b0;
    #2;
    check_eq("t6_async_kp", keypad, 8'h00);
    check_eq("t6_async_col", {4'h0, col_out}, 8'h0E);
    check_eq("t6_async_ovf", {7'd0, overflow}, 8'h00);
    release_reset();

    // randomized key activity against the reference
    cur = 16'h0;
    for (int f = 0; f < 300; f++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel >= 4 && sel <= 5) cur = 16'h0;
      else if (sel >= 6) cur = 16'(1 << $urandom_range(0, 15));
      frame(cur, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
